// File: rtl/memory_unit.sv
// memory_unit
//   Word-addressed memory sitting beside the CPU on its memory bus.
//   After reset it zeroes every word (CLEAR). It then accepts a program image
//   through a streaming load port (LOAD). Finally it releases the CPU from reset
//   and serves CPU reads and writes (RUN). RUN holds until the next rst.
//
// Ports
//   clk        in   single clock, all state updates on the rising edge
//   rst        in   synchronous, active-high reset
//   addr       in   CPU word address
//   data       in   CPU write data
//   we         in   CPU write enable (honoured in RUN only)
//   mem        out  registered read data to the CPU (0 outside RUN)
//   ld_valid   in   load word valid
//   ld_data    in   load word
//   ld_last    in   final load word marker, only meaningful with ld_valid
//   ld_ready   out  unit accepts a load word this cycle
//   cpu_rst_n  out  active-low CPU reset, rises the cycle after RUN is entered
//   ld_ovf     out  sticky: the image filled the array without ld_last
//   dbg_state  out  current FSM state, for observation only
//
// Load handshake: a word transfers on a rising edge where ld_valid && ld_ready.
// ld_ready is high for the whole of LOAD, whether or not ld_valid is asserted.
// With ld_valid low nothing changes. ld_data and ld_last are only looked at
// when a transfer happens.

module memory_unit #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  we,
   output logic [DATA_WIDTH-1:0] mem,
   input  logic                  ld_valid,
   input  logic [DATA_WIDTH-1:0] ld_data,
   input  logic                  ld_last,
   output logic                  ld_ready,
   output logic                  cpu_rst_n,
   output logic                  ld_ovf,
   output logic [1:0]            dbg_state
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_LOAD  = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;
   logic [ADDR_WIDTH-1:0]   r_ptr;
   logic [DATA_WIDTH-1:0]   r_mem;
   logic                    r_cpu_rst_n;
   logic                    r_ld_ovf;
   logic [DATA_WIDTH-1:0]   r_array [0:DEPTH-1];

   logic                    w_xfer;
   logic                    w_arr_we;
   logic [ADDR_WIDTH-1:0]   w_arr_addr;
   logic [DATA_WIDTH-1:0]   w_arr_wdata;

   assign w_xfer = (r_state == S_LOAD) && ld_valid;

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_CLEAR: if (r_ptr == LAST_ADDR) w_next_state = S_LOAD;
         S_LOAD:  if (w_xfer && (ld_last || (r_ptr == LAST_ADDR))) w_next_state = S_RUN;
         S_RUN:   w_next_state = S_RUN;
         default: w_next_state = S_CLEAR;
      endcase
   end

   // Single array write port, shared by clear, load and the CPU.
   // rst gates it so the reset cycle itself leaves the array untouched.
   always_comb begin
      w_arr_we    = 1'b0;
      w_arr_addr  = r_ptr;
      w_arr_wdata = '0;
      if (!rst) begin
         case (r_state)
            S_CLEAR: w_arr_we = 1'b1;
            S_LOAD: begin
               w_arr_we    = ld_valid;
               w_arr_wdata = ld_data;
            end
            S_RUN: begin
               w_arr_we    = we;
               w_arr_addr  = addr;
               w_arr_wdata = data;
            end
            default: w_arr_we = 1'b0;
         endcase
      end
   end

   // Control state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_CLEAR;
         r_ptr       <= '0;
         r_cpu_rst_n <= 1'b0;
         r_ld_ovf    <= 1'b0;
      end else begin
         r_state <= w_next_state;
         // ptr wraps from LAST_ADDR to 0 on its own, ready for LOAD after CLEAR
         if ((r_state == S_CLEAR) || w_xfer) r_ptr <= r_ptr + 1'b1;
         // Registered from the current state so the CPU leaves reset one
         // cycle after RUN is entered.
         r_cpu_rst_n <= (r_state == S_RUN);
         if (w_xfer && (r_ptr == LAST_ADDR) && !ld_last) r_ld_ovf <= 1'b1;
      end
   end

   // Registered read port. A CPU write is write-first: the new data is
   // forwarded straight into mem.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem <= '0;
      end else if (r_state == S_RUN) begin
         if (we) r_mem <= data;
         else    r_mem <= r_array[addr];
      end else begin
         r_mem <= '0;
      end
   end

   // Array storage, deliberately without reset (CLEAR zeroes it)
   always_ff @(posedge clk) begin
      if (w_arr_we) r_array[w_arr_addr] <= w_arr_wdata;
   end

   assign mem       = r_mem;
   assign ld_ready  = (r_state == S_LOAD);
   assign cpu_rst_n = r_cpu_rst_n;
   assign ld_ovf    = r_ld_ovf;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit
//   Directed and randomized bench for memory_unit. A plain array model of the
//   memory holds the expected contents. It is zeroed on every reset, filled in
//   load order, and updated by CPU writes.

module tb_memory_unit;

   localparam int AW    = 6;
   localparam int DW    = 16;
   localparam int DEPTH = 2 ** AW;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;
   logic          we;
   logic [DW-1:0] mem;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_last;
   logic          ld_ready;
   logic          cpu_rst_n;
   logic          ld_ovf;
   logic [1:0]    dbg_state;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mdl [0:DEPTH-1];
   int            mptr;

   memory_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .data      (data),
      .we        (we),
      .mem       (mem),
      .ld_valid  (ld_valid),
      .ld_data   (ld_data),
      .ld_last   (ld_last),
      .ld_ready  (ld_ready),
      .cpu_rst_n (cpu_rst_n),
      .ld_ovf    (ld_ovf),
      .dbg_state (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   // One clock: the rising edge happens, then inputs are driven and outputs
   // are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reset pulse, then CLEAR. ld_ready must rise exactly 64 edges after rst drops.
   task automatic do_reset();
      rst = 1'b1;
      step();
      check("rst_mem", mem, '0);
      check("rst_ld_ready", {15'd0, ld_ready}, 16'd0);
      check("rst_cpu_rst_n", {15'd0, cpu_rst_n}, 16'd0);
      check("rst_ld_ovf", {15'd0, ld_ovf}, 16'd0);
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
      mptr = 0;
      repeat (DEPTH - 1) step();
      check("clear_ready_63", {15'd0, ld_ready}, 16'd0);
      check("clear_mem_0", mem, '0);
      step();
      check("clear_ready_64", {15'd0, ld_ready}, 16'd1);
      check("clear_cpu_rst_n", {15'd0, cpu_rst_n}, 16'd0);
   endtask

   // One load transfer; the model takes the word at the next load pointer.
   task automatic load_word(input logic [DW-1:0] d, input logic last);
      check("load_ready", {15'd0, ld_ready}, 16'd1);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      step();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      ld_data  = $urandom_range(0, 16'hFFFF);
      mdl[mptr] = d;
      mptr++;
   endtask

   // One CPU cycle in RUN. The expected mem is the model's word, or the new
   // data on a write.
   task automatic cpu_op(input string tag, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
      logic [DW-1:0] exp;
      we   = w;
      addr = a;
      data = d;
      if (w) mdl[a] = d;
      exp = mdl[a];
      step();
      check(tag, mem, exp);
      we = 1'b0;
   endtask

   initial begin
      rst = 1'b1; addr = '0; data = '0; we = 1'b0;
      ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
      @(negedge clk);

      // 1 + 2: reset, idle CLEAR, three-word load
      do_reset();
      step();
      step();
      check("idle_ready_held", {15'd0, ld_ready}, 16'd1);
      load_word(16'h7100, 1'b0);
      load_word(16'h8100, 1'b0);
      load_word(16'h1234, 1'b1);
      check("run_ready_low", {15'd0, ld_ready}, 16'd0);
      check("run_cpu_rst_n_0", {15'd0, cpu_rst_n}, 16'd0);
      step();
      check("run_cpu_rst_n_1", {15'd0, cpu_rst_n}, 16'd1);
      cpu_op("rd_a0", 1'b0, 6'd0, '0);
      check("rd_a0_const", mem, 16'h7100);
      cpu_op("rd_a1", 1'b0, 6'd1, '0);
      check("rd_a1_const", mem, 16'h8100);
      cpu_op("rd_a2", 1'b0, 6'd2, '0);
      check("rd_a2_const", mem, 16'h1234);
      cpu_op("rd_a3", 1'b0, 6'd3, '0);

      // 3: write-first, then read back
      cpu_op("wr_a5", 1'b1, 6'd5, 16'hBEEF);
      cpu_op("rd_a5", 1'b0, 6'd5, '0);
      check("rd_a5_const", mem, 16'hBEEF);

      // Random CPU traffic against the model
      for (int i = 0; i < 60; i++) begin
         cpu_op("rand_op", ($urandom_range(0, 2) == 0), AW'($urandom_range(0, DEPTH - 1)),
                DW'($urandom_range(0, 16'hFFFF)));
      end
      // The load port is ignored in RUN
      ld_valid = 1'b1; ld_last = 1'b1; ld_data = 16'hDEAD;
      cpu_op("run_ld_ignored", 1'b0, 6'd3, '0);
      ld_valid = 1'b0; ld_last = 1'b0;
      check("run_ovf_clear", {15'd0, ld_ovf}, 16'd0);

      // 6: rst during RUN discards all contents; we is ignored in CLEAR/LOAD
      cpu_op("wr_a9", 1'b1, 6'd9, 16'hAAAA);
      rst = 1'b1;
      we = 1'b1; addr = 6'd9; data = 16'h5555;
      step();
      check("rst_run_cpu_rst_n", {15'd0, cpu_rst_n}, 16'd0);
      check("rst_run_ready", {15'd0, ld_ready}, 16'd0);
      do_reset();
      we = 1'b1; addr = 6'd10; data = 16'h1111;
      load_word(16'h0F0F, 1'b1);
      we = 1'b0;
      step();
      check("rerun_cpu_rst_n", {15'd0, cpu_rst_n}, 16'd1);
      cpu_op("rerun_a9", 1'b0, 6'd9, '0);
      check("rerun_a9_zero", mem, 16'h0000);
      cpu_op("rerun_a10", 1'b0, 6'd10, '0);
      cpu_op("rerun_a0", 1'b0, 6'd0, '0);

      // 4: full 64-word load without ld_last
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         if (i == DEPTH - 1) check("ovf_before_last", {15'd0, ld_ovf}, 16'd0);
         load_word(DW'($urandom_range(0, 16'hFFFF)), 1'b0);
      end
      check("ovf_set", {15'd0, ld_ovf}, 16'd1);
      check("ovf_ready_low", {15'd0, ld_ready}, 16'd0);
      ld_valid = 1'b1; ld_data = 16'hFFFF; ld_last = 1'b0;
      step();
      step();
      ld_valid = 1'b0;
      check("ovf_cpu_rst_n", {15'd0, cpu_rst_n}, 16'd1);
      for (int a = 0; a < DEPTH; a++) cpu_op("full_rd", 1'b0, AW'(a), '0);
      check("ovf_sticky", {15'd0, ld_ovf}, 16'd1);

      // 5: stalls and ld_last without ld_valid
      do_reset();
      check("reset_clears_ovf", {15'd0, ld_ovf}, 16'd0);
      load_word(16'hA001, 1'b0);
      for (int s = 0; s < 2; s++) begin
         ld_valid = 1'b0; ld_last = 1'b1; ld_data = 16'hBAD0;
         step();
         check("stall_ready", {15'd0, ld_ready}, 16'd1);
      end
      ld_last = 1'b0;
      load_word(16'hA002, 1'b1);
      check("stall_run_ready", {15'd0, ld_ready}, 16'd0);
      step();
      for (int a = 0; a < 4; a++) cpu_op("stall_rd", 1'b0, AW'(a), '0);
      check("stall_ovf", {15'd0, ld_ovf}, 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
